// File: rtl/i2s_tx_scheduler.sv
// I2S transmit frame scheduler: 32-slot mono left-justified frames, round-robin
// sharing of the serial line between two 16-bit requesters, idle word otherwise.
module i2s_tx_scheduler #(
    parameter logic [15:0] IDLE_WORD = 16'h0000
) (
    input  logic        clk3,
    input  logic        reset,
    input  logic        en,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        lrclk,
    output logic        sdata,
    output logic [1:0]  owner,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] word;
    logic        last_grant;   // 1 = requester 1 was granted most recently

    logic        grant0;
    logic        grant1;
    logic        decide;
    logic [15:0] pick_word;
    logic [4:0]  next_slot;

    always_comb begin
        grant0    = req0 & (~req1 | last_grant);
        grant1    = req1 & (~req0 | ~last_grant);
        pick_word = grant0 ? data0 : (grant1 ? data1 : IDLE_WORD);
        next_slot = cnt + 5'd1;
        decide    = en & ((state == IDLE) | (cnt == 5'd31));
    end

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            word       <= 16'h0000;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            owner      <= 2'b00;
            busy       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (decide) begin
                // Slot 0 of the new frame is presented straight from the capture.
                state <= RUN;
                cnt   <= 5'd0;
                word  <= pick_word;
                sdata <= pick_word[15];
                lrclk <= 1'b0;
                ack0  <= grant0;
                ack1  <= grant1;
                owner <= {grant1, grant0};
                busy  <= 1'b1;
                if (grant0 | grant1) begin
                    last_grant <= grant1;
                end
            end else if (state == RUN && cnt != 5'd31) begin
                cnt   <= next_slot;
                sdata <= word[~next_slot[3:0]];
                lrclk <= next_slot[4];
            end else begin
                state <= IDLE;
                cnt   <= 5'd0;
                sdata <= 1'b0;
                lrclk <= 1'b0;
                owner <= 2'b00;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Scoreboard bench for i2s_tx_scheduler: stimulus queues expected frames, a
// negedge monitor reassembles each frame from the serial outputs and compares.
module tb_i2s_tx_scheduler;

    logic        clk3 = 1'b0;
    logic        reset;
    logic        en;
    logic        req0;
    logic [15:0] data0;
    logic        req1;
    logic [15:0] data1;
    logic        ack0;
    logic        ack1;
    logic        lrclk;
    logic        sdata;
    logic [1:0]  owner;
    logic        busy;

    i2s_tx_scheduler #(.IDLE_WORD(16'hF00F)) dut (
        .clk3  (clk3),
        .reset (reset),
        .en    (en),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .ack0  (ack0),
        .ack1  (ack1),
        .lrclk (lrclk),
        .sdata (sdata),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk3 = ~clk3;

    typedef struct {
        logic [1:0]  owner;
        logic [15:0] word;
        int          nslots;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] o, input logic [15:0] w, input int n);
        exp_t e;
        e.owner  = o;
        e.word   = w;
        e.nslots = n;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk3);
        #1;
    endtask

    task automatic frame_wait();
        repeat (32) tick();
    endtask

    function automatic logic [6:0] outs();
        return {lrclk, sdata, ack0, ack1, owner, busy};
    endfunction

    // Monitor state
    logic        in_frame = 1'b0;
    int          slot = 0;
    logic [31:0] sd, lr, a0, a1;
    logic [1:0]  own_first;
    logic        own_stable;
    int          frame_no = 0;

    task automatic finalize();
        exp_t        e;
        logic [31:0] mask;
        in_frame = 1'b0;
        check("frame_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 32; i++) mask[31-i] = (i < e.nslots);
            $display("frame %0d: owner=%b sdata=%h lrclk=%h ack0=%h ack1=%h slots=%0d",
                     frame_no, own_first, sd, lr, a0, a1, slot);
            check("slots", slot, e.nslots);
            check("owner", {30'd0, own_first}, {30'd0, e.owner});
            check("owner_held", {31'd0, own_stable}, 32'd1);
            check("sdata", sd & mask, {e.word, e.word} & mask);
            check("lrclk", lr & mask, 32'h0000FFFF & mask);
            check("ack0", a0, (e.owner == 2'b01) ? 32'h80000000 : 32'h0);
            check("ack1", a1, (e.owner == 2'b10) ? 32'h80000000 : 32'h0);
        end
        frame_no++;
    endtask

    initial begin
        forever begin
            @(negedge clk3);
            if (busy === 1'b1) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    slot       = 0;
                    sd         = '0;
                    lr         = '0;
                    a0         = '0;
                    a1         = '0;
                    own_first  = owner;
                    own_stable = 1'b1;
                end
                sd[31-slot] = sdata;
                lr[31-slot] = lrclk;
                a0[31-slot] = ack0;
                a1[31-slot] = ack1;
                if (owner !== own_first) own_stable = 1'b0;
                slot++;
                if (slot == 32) finalize();
            end else if (in_frame) begin
                finalize();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 16'h0000;
        data1 = 16'h0000;

        // Reset values, then 40 idle cycles with en low
        repeat (3) begin
            tick();
            check("reset_outs", {25'd0, outs()}, 32'd0);
        end
        reset = 1'b1;
        repeat (40) begin
            tick();
            check("idle_outs", {25'd0, outs()}, 32'd0);
        end

        // Contention: tie goes to req0 first, then alternates
        en = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 16'hAAAA; data1 = 16'h5555;
        push(2'b01, 16'hAAAA, 32);
        push(2'b10, 16'h5555, 32);
        push(2'b01, 16'hAAAA, 32);
        push(2'b10, 16'h5555, 32);
        tick();
        repeat (3) frame_wait();
        req0 = 1'b0; req1 = 1'b0;

        // Idle fill frame, then a single requester, then idle again
        push(2'b00, 16'hF00F, 32);
        frame_wait();
        req0 = 1'b1; data0 = 16'hDB6E;
        push(2'b01, 16'hDB6E, 32);
        frame_wait();
        req0 = 1'b0;
        push(2'b00, 16'hF00F, 32);
        frame_wait();

        // Enable drop at slot 8; req1 pending at slot 31 must not be acked
        repeat (8) tick();
        en = 1'b0;
        repeat (12) tick();
        req1 = 1'b1; data1 = 16'h1234;
        repeat (11) tick();
        check("slot31_busy", {31'd0, busy}, 32'd1);
        repeat (4) begin
            tick();
            check("drop_outs", {25'd0, outs()}, 32'd0);
        end

        // Mid-frame reset at slot 20
        en = 1'b1;
        push(2'b10, 16'h1234, 20);
        tick();
        repeat (20) tick();
        reset = 1'b0;
        #1;
        check("async_reset_outs", {25'd0, outs()}, 32'd0);
        repeat (2) begin
            tick();
            check("reset_hold_outs", {25'd0, outs()}, 32'd0);
        end
        reset = 1'b1;
        push(2'b10, 16'h1234, 32);
        tick();
        req1 = 1'b0;

        // en dropped at slot 3 and re-asserted in slot 31: no gap
        push(2'b00, 16'hF00F, 32);
        frame_wait();
        repeat (3) tick();
        en = 1'b0;
        repeat (28) tick();
        en = 1'b1;
        push(2'b00, 16'hF00F, 32);
        tick();
        check("reassert_busy", {31'd0, busy}, 32'd1);
        en = 1'b0;
        repeat (32) tick();
        check("final_idle_outs", {25'd0, outs()}, 32'd0);
        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_scheduler.md
# i2s_tx_scheduler

Frame-level scheduler for the alarm's I2S transmit path. Runs on the serial bit clock, generates the 32-slot frame and word-select, and shares the single serial data line between two 16-bit sample requesters (e.g. alarm tone and chime) with round-robin arbitration at frame boundaries. When neither requester has a sample, it fills the frame with a fixed idle word.

## Interface
Parameters:
- `IDLE_WORD`, default 16'h0000: word transmitted in frames with no grant.

Ports (clock and reset first):
- `clk3`  in  1  serial bit clock (S_CLK domain, 128 kHz); all logic on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `en`  in  1  transmit enable.
- `req0`  in  1  requester 0 has a sample pending.
- `data0`  in  16  requester 0 sample; stable while `req0` is high until `ack0`.
- `req1`  in  1  requester 1 has a sample pending.
- `data1`  in  16  requester 1 sample; stable while `req1` is high until `ack1`.
- `ack0`  out  1  one-cycle pulse: `data0` captured.
- `ack1`  out  1  one-cycle pulse: `data1` captured.
- `lrclk`  out  1  word select; 0 = left half, 1 = right half.
- `sdata`  out  1  serial data, MSB first.
- `owner`  out  2  current frame source: 01 = req0, 10 = req1, 00 = idle word.
- `busy`  out  1  high while in RUN.

## Operation
- Two states: IDLE and RUN. Slot counter `cnt` runs 0..31 in RUN and wraps 31→0.
- Frame format: mono, left-justified. The same captured word is sent in both halves: slots 0..15 carry word[15..0] with `lrclk`=0; slots 16..31 carry word[15..0] with `lrclk`=1.
- **Decision point:** the edge ending slot 31 in RUN, or the edge at which `en` is first sampled high in IDLE.
  - Sample `req0`/`req1`.
  - If exactly one is high, grant it.
  - If both are high, grant the one not granted most recently. The `last_grant` register resets to 1, so `req0` wins the first tie.
  - If neither is high, load `IDLE_WORD`, set `owner`=00, assert no ack, and leave `last_grant` unchanged.
  - The granted data is captured into the shift/hold register at that same edge.
- **Ack:** the granted `ackN` is high for exactly slot 0 of the new frame (one clk3 cycle).
  - A requester that holds `req` high after ack is re-arbitrated at the next decision point.
  - Requests asserted mid-frame wait for the next decision point. Inputs between decision points are ignored.
- **`en` deasserted during RUN:** the current frame completes through slot 31. At that edge there is no decision and no ack, and the block enters IDLE.
- **`en` re-asserted in slot 31 before the boundary:** RUN continues seamlessly (the decision is made normally).
- **IDLE outputs:** `cnt`=0, `lrclk`=0, `sdata`=0, `owner`=00, `busy`=0, acks 0.
- **Reset (async, any time, including mid-frame):** state IDLE, `cnt`=0, `lrclk`=0, `sdata`=0, `ack0`=`ack1`=0, `owner`=00, `busy`=0, `last_grant`=1. The partial frame is discarded and no ack is issued for it.

## Timing
- All outputs are registered and change only on the clk3 rising edge (or async reset).
- **Latency:** the decision edge is followed by slot 0. In that slot `sdata`=word[15], `lrclk`=0, `ackN`=1, and `owner` and `busy` are valid.
- `owner` is held constant for all 32 slots of a frame.
- `lrclk` rises at the start of slot 16 and falls at the start of slot 0. With S_CLK at 128 kHz the frame rate is 4 kHz.
- Back-to-back frames have no gap: slot 31 is followed directly by slot 0 of the next frame.
- From IDLE, the first slot 0 begins one cycle after the edge that samples `en`=1.

## Test plan
- **Reset values:** hold `reset`=0, toggle clk3 → `lrclk`=0, `sdata`=0, `ack0`=`ack1`=0, `owner`=00, `busy`=0. Release `reset`, keep `en`=0 for 40 cycles → outputs stay the same.
- **Single requester:** `en`=1, `req0`=1, `data0`=16'hDB6E.
  - `ack0` is high only in slot 0 and `owner`=01.
  - `sdata` over slots 0..15 = 1101101101101110, with `lrclk`=0.
  - Slots 16..31 repeat the same bits with `lrclk`=1.
- **Contention:** `req0`=`req1`=1 held continuously, `data0`=16'hAAAA, `data1`=16'h5555 → `owner` sequence 01,10,01,10 over four frames; each ack pulses once per granted frame.
- **Idle fill:** `IDLE_WORD`=16'hF00F, no requests → `sdata` = 1111000000001111 in each half, `owner`=00, no ack pulses, `lrclk` still toggling.
- **Enable drop:** deassert `en` at slot 8 → slots 9..31 complete normally, then `busy`=0 and `lrclk`=0. A `req1` pending at slot 31 gets no ack.
- **Mid-frame reset:** assert `reset` at slot 20 → all outputs return to their reset values immediately. After release with `en`=1 and `req1`=1, `req1` is granted and `ack1` pulses in slot 0 of the first frame.
